// File: rtl/alu_rr_sched.sv
// ---------------------------------------------------------------------------
// alu_rr_sched
//   Round-robin scheduler sharing one WIDTH-bit ALU between two requesters.
//   Each operation runs IDLE (accept) -> EXEC (compute, register) -> RESP
//   (hold result until the granted requester takes it).
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   per-requester accept handshake (ready is a one-cycle
//                         combinational pulse in IDLE)
//   req{0,1}_a/_b/_op     operands and op select per requester
//   rsp_valid/rsp_ready   per-requester response handshake
//   rsp_sum/carry/ovf/out registered ALU results
//   busy                  high whenever the FSM is not in IDLE
//
// Optional build macro ALU_RR_SCHED_STATS_EN
//   Adds done_cnt0/done_cnt1: 8-bit wrapping counts of completed responses.
// ---------------------------------------------------------------------------
module alu_rr_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_carry,
    output logic             rsp_ovf,
    output logic             rsp_out,
    output logic             busy
`ifdef ALU_RR_SCHED_STATS_EN
    ,
    output logic [7:0]       done_cnt0,
    output logic [7:0]       done_cnt1
`endif
);

    localparam int MSB = WIDTH - 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
    } alu_req_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
        logic             out;
    } alu_rsp_t;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    // SUB is a + (-b); LT and EQ reuse the SUB result.
    function automatic alu_rsp_t alu_eval(input alu_req_t r);
        logic [WIDTH-1:0] nb;
        logic [WIDTH:0]   add_r;
        logic [WIDTH:0]   sub_r;
        logic             add_ovf;
        logic             sub_ovf;
        alu_rsp_t         res;
        nb      = '0 - r.b;
        add_r   = {1'b0, r.a} + {1'b0, r.b};
        sub_r   = {1'b0, r.a} + {1'b0, nb};
        add_ovf = (r.a[MSB] == r.b[MSB]) && (add_r[MSB] != r.a[MSB]);
        sub_ovf = (r.a[MSB] == nb[MSB])  && (sub_r[MSB] != r.a[MSB]);
        res     = '0;
        case (r.op)
            3'd0: begin res.sum = add_r[WIDTH-1:0]; res.carry = add_r[WIDTH]; res.ovf = add_ovf; end
            3'd1: begin res.sum = sub_r[WIDTH-1:0]; res.carry = sub_r[WIDTH]; res.ovf = sub_ovf; end
            3'd2: res.sum = ~r.a;
            3'd3: res.sum = r.a & r.b;
            3'd4: res.sum = r.a | r.b;
            3'd5: res.sum = r.a ^ r.b;
            3'd6: res.out = sub_r[MSB] ^ sub_ovf;
            default: res.out = (sub_r[WIDTH-1:0] == '0);
        endcase
        return res;
    endfunction

    state_t   state;
    logic     gnt_q;        // requester being served
    logic     last_served;
    alu_req_t op_q;

    logic     gnt;
    alu_req_t sel_req;
    alu_rsp_t alu_res;

    // Grant: a lone requester wins; on a tie the one not last served wins.
    always_comb begin
        gnt       = 1'b0;
        req_ready = 2'b00;
        case (req_valid)
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_served;
            default: gnt = 1'b0;
        endcase
        if (state == S_IDLE && |req_valid)
            req_ready[gnt] = 1'b1;
        sel_req = gnt ? alu_req_t'{req1_a, req1_b, req1_op}
                      : alu_req_t'{req0_a, req0_b, req0_op};
        alu_res = alu_eval(op_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            gnt_q       <= 1'b0;
            last_served <= 1'b1;
            op_q        <= '0;
            rsp_valid   <= 2'b00;
            rsp_sum     <= '0;
            rsp_carry   <= 1'b0;
            rsp_ovf     <= 1'b0;
            rsp_out     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        op_q  <= sel_req;
                        gnt_q <= gnt;
                        busy  <= 1'b1;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_sum   <= alu_res.sum;
                    rsp_carry <= alu_res.carry;
                    rsp_ovf   <= alu_res.ovf;
                    rsp_out   <= alu_res.out;
                    rsp_valid <= gnt_q ? 2'b10 : 2'b01;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    // Only the granted requester's ready completes the response.
                    if (rsp_ready[gnt_q]) begin
                        last_served <= gnt_q;
                        rsp_valid   <= 2'b00;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_RR_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt0 <= 8'd0;
            done_cnt1 <= 8'd0;
        end else if (state == S_RESP && rsp_ready[gnt_q]) begin
            if (gnt_q) done_cnt1 <= done_cnt1 + 8'd1;
            else       done_cnt0 <= done_cnt0 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_sched
//   Self-checking bench for alu_rr_sched (WIDTH=4): directed vector table,
//   randomized transactions against an integer-arithmetic reference model,
//   and hand-written sequences for stall, alternation and reset-in-EXEC.
//   Define ALU_RR_SCHED_STATS_EN to also check the completion counters.
// ---------------------------------------------------------------------------
module tb_alu_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [3:0] rsp_sum;
    logic       rsp_carry, rsp_ovf, rsp_out, busy;
`ifdef ALU_RR_SCHED_STATS_EN
    logic [7:0] done_cnt0, done_cnt1;
`endif

    alu_rr_sched #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
        .rsp_out(rsp_out), .busy(busy)
`ifdef ALU_RR_SCHED_STATS_EN
        , .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int mdl_last = 1;
    int mdl_cnt[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] res_bus();
        return {rsp_sum, rsp_carry, rsp_ovf, rsp_out};
    endfunction

    // Reference ALU using plain integer arithmetic: {sum,carry,ovf,out}.
    function automatic logic [6:0] ref_alu(input int a, input int b, input int op);
        int nb, as, nbs, bs, s, ss;
        logic [3:0] sum;
        logic c, v, o;
        nb  = (16 - b) % 16;
        as  = (a  >= 8) ? a  - 16 : a;
        bs  = (b  >= 8) ? b  - 16 : b;
        nbs = (nb >= 8) ? nb - 16 : nb;
        sum = 4'd0; c = 1'b0; v = 1'b0; o = 1'b0;
        case (op)
            0: begin s = a + b;  ss = as + bs;  sum = 4'(s % 16); c = (s >= 16); v = (ss > 7 || ss < -8); end
            1: begin s = a + nb; ss = as + nbs; sum = 4'(s % 16); c = (s >= 16); v = (ss > 7 || ss < -8); end
            2: sum = 4'(15 - a);
            3: sum = 4'(a & b);
            4: sum = 4'(a | b);
            5: sum = 4'(a ^ b);
            6: o = ((as + nbs) < 0);
            default: o = (a == b);
        endcase
        return {sum, c, v, o};
    endfunction

    task automatic do_reset();
        req_valid = 2'b00; rsp_ready = 2'b00;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        mdl_last = 1; mdl_cnt[0] = 0; mdl_cnt[1] = 0;
    endtask

    // One complete transaction. Starts and ends with the DUT in IDLE.
    task automatic txn(input logic [1:0] vld,
                       input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] o0,
                       input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] o1,
                       input int stall, input logic [6:0] exp);
        int g;
        logic [1:0] oh;
        @(posedge clk); #1;
        req_valid = vld; rsp_ready = 2'b00;
        req0_a = a0; req0_b = b0; req0_op = o0;
        req1_a = a1; req1_b = b1; req1_op = o1;
        g  = (vld == 2'b11) ? 1 - mdl_last : ((vld == 2'b10) ? 1 : 0);
        oh = (g == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        chk("accept_ready", req_ready, oh);
        chk("accept_busy", busy, 0);
        @(posedge clk); #1;
        // scramble operands: only the accept cycle may be sampled
        req_valid = 2'b00;
        req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 3'($urandom);
        req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 3'($urandom);
        @(negedge clk);
        chk("exec_ready", req_ready, 0);
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_busy", busy, 1);
        @(negedge clk);
        chk("resp_valid", rsp_valid, oh);
        chk("resp_data", res_bus(), exp);
        for (int i = 0; i < stall; i++) begin
            rsp_ready = ~oh;        // other requester's ready must be ignored
            req_valid = 2'b11;
            @(negedge clk);
            chk("stall_valid", rsp_valid, oh);
            chk("stall_data", res_bus(), exp);
            chk("stall_ready", req_ready, 0);
            chk("stall_busy", busy, 1);
        end
        req_valid = 2'b00;
        rsp_ready = oh;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        mdl_last = g;
        mdl_cnt[g] = (mdl_cnt[g] + 1) % 256;
        @(negedge clk);
        chk("done_busy", busy, 0);
        chk("done_rsp_valid", rsp_valid, 0);
`ifdef ALU_RR_SCHED_STATS_EN
        chk("done_cnt0", done_cnt0, mdl_cnt[0]);
        chk("done_cnt1", done_cnt1, mdl_cnt[1]);
`endif
    endtask

    typedef struct {
        logic [1:0] vld;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [6:0] exp;   // {sum, carry, ovf, out}
    } vec_t;

    vec_t tbl[11];

    initial begin
        int acc_cyc[$];
        int acc_g[$];
        int cyc;
        logic [6:0] saved;

        tbl[0]  = '{2'b01, 4'd7,  4'd1,  3'd0, {4'd8,  3'b010}};
        tbl[1]  = '{2'b10, 4'd3,  4'd5,  3'd1, {4'd14, 3'b000}};
        tbl[2]  = '{2'b10, 4'd3,  4'd5,  3'd6, {4'd0,  3'b001}};
        tbl[3]  = '{2'b10, 4'd9,  4'd9,  3'd7, {4'd0,  3'b001}};
        tbl[4]  = '{2'b01, 4'd5,  4'd0,  3'd1, {4'd5,  3'b000}};
        tbl[5]  = '{2'b01, 4'd15, 4'd1,  3'd0, {4'd0,  3'b100}};
        tbl[6]  = '{2'b01, 4'd12, 4'd10, 3'd2, {4'd3,  3'b000}};
        tbl[7]  = '{2'b10, 4'd12, 4'd10, 3'd3, {4'd8,  3'b000}};
        tbl[8]  = '{2'b01, 4'd12, 4'd10, 3'd4, {4'd14, 3'b000}};
        tbl[9]  = '{2'b10, 4'd12, 4'd10, 3'd5, {4'd6,  3'b000}};
        tbl[10] = '{2'b01, 4'd8,  4'd1,  3'd1, {4'd7,  3'b110}};

        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        do_reset();

        // reset state
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_data", res_bus(), 0);
        chk("rst_busy", busy, 0);
`ifdef ALU_RR_SCHED_STATS_EN
        chk("rst_cnt0", done_cnt0, 0);
        chk("rst_cnt1", done_cnt1, 0);
`endif

        // directed vectors, same operands on the unused requester
        for (int i = 0; i < 11; i++)
            txn(tbl[i].vld, tbl[i].a, tbl[i].b, tbl[i].op,
                tbl[i].a, tbl[i].b, tbl[i].op, 0, tbl[i].exp);

        // long stall in RESP
        txn(2'b01, 4'd7, 4'd1, 3'd0, 4'd2, 4'd2, 3'd0, 5, {4'd8, 3'b010});

        // randomized against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [1:0] v;
            logic [3:0] a0, b0, a1, b1;
            logic [2:0] o0, o1;
            int g;
            v  = 2'($urandom_range(1, 3));
            a0 = 4'($urandom); b0 = 4'($urandom); o0 = 3'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom); o1 = 3'($urandom);
            g  = (v == 2'b11) ? 1 - mdl_last : ((v == 2'b10) ? 1 : 0);
            txn(v, a0, b0, o0, a1, b1, o1, $urandom_range(0, 3),
                (g == 1) ? ref_alu(a1, b1, o1) : ref_alu(a0, b0, o0));
        end

        // both requesters held valid, rsp_ready tied high
        do_reset();
        @(posedge clk); #1;
        req0_a = 4'd1; req0_b = 4'd2; req0_op = 3'd0;
        req1_a = 4'd3; req1_b = 4'd4; req1_op = 3'd0;
        req_valid = 2'b11; rsp_ready = 2'b11;
        cyc = 0;
        while (cyc < 16) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                acc_cyc.push_back(cyc);
                acc_g.push_back(req_ready == 2'b10 ? 1 : 0);
            end
            cyc++;
        end
        req_valid = 2'b00;
        chk("alt_count", (acc_cyc.size() >= 4), 1);
        for (int i = 0; i < 4 && i < acc_cyc.size(); i++) begin
            chk("alt_grant", acc_g[i], i % 2);
            if (i > 0) chk("alt_interval", acc_cyc[i] - acc_cyc[i-1], 3);
        end
        repeat (4) @(posedge clk);
        rsp_ready = 2'b00;

        // reset while in EXEC
        do_reset();
        txn(2'b01, 4'd7, 4'd1, 3'd0, 4'd0, 4'd0, 3'd0, 0, {4'd8, 3'b010});
        saved = res_bus();
        chk("pre_rst_data", saved, {4'd8, 3'b010});
        @(posedge clk); #1;
        req_valid = 2'b10; req1_a = 4'd15; req1_b = 4'd15; req1_op = 3'd0;
        @(posedge clk); #1;                 // now in EXEC
        req_valid = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        chk("exec_rst_ready", req_ready, 0);
        chk("exec_rst_rsp_valid", rsp_valid, 0);
        chk("exec_rst_data", res_bus(), 0);
        chk("exec_rst_busy", busy, 0);
`ifdef ALU_RR_SCHED_STATS_EN
        chk("exec_rst_cnt0", done_cnt0, 0);
`endif
        @(posedge clk); #3 rst_n = 1'b1;
        mdl_last = 1; mdl_cnt[0] = 0; mdl_cnt[1] = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", rsp_valid, 0);
            chk("post_rst_busy", busy, 0);
        end

`ifdef ALU_RR_SCHED_STATS_EN
        // counter wrap after 256 completions
        for (int i = 0; i < 256; i++)
            txn(2'b01, 4'd1, 4'd1, 3'd3, 4'd0, 4'd0, 3'd0, 0, {4'd1, 3'b000});
        chk("wrap_cnt0", done_cnt0, 0);
        chk("wrap_cnt1", done_cnt1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
